fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter register. Each cycle it may issue the current `pc` as a single-outstanding request to instruction memory. It tells the PC register when that address has been consumed, and buffers returned instructions with their PC in a small FIFO for decode. A control-flow redirect flushes the buffer and discards any in-flight response.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage sitting behind the PC register. Issues the current
//   pc as a single-outstanding request to instruction memory. Tells the PC
//   register when that address has been consumed. Buffers returned
//   instructions together with their PC in a DEPTH-entry FIFO for decode.
//   A redirect flushes the FIFO and discards any response still in flight.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   pc                  current PC register value (word address)
//   redirect            PC register loads a non-sequential target; flush
//   pc_advance          pc accepted by memory this cycle; PC register steps
//   imem_req/addr/gnt   memory request handshake (addr always equals pc)
//   imem_rvalid/rdata   memory read response
//   inst_valid/ready    FIFO head handshake towards decode
//   inst, inst_pc       head instruction and its PC
module fetch_unit #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        redirect,
   output logic        pc_advance,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL      = DEPTH[AW:0];
   localparam logic [AW:0] NEAR_FULL = FULL - 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t        state;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   req_pc;
   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic          push;
   logic          pop;

   // A new request is only raised when the FIFO has room for its response
   // even if nothing is popped meanwhile; inst_ready is deliberately not
   // credited so there is no path from decode back to memory.
   always_comb begin
      imem_req = 1'b0;
      if (!reset && !redirect) begin
         if (state == IDLE) begin
            imem_req = (count < FULL);
         end else if (state == WAIT) begin
            imem_req = imem_rvalid && (count < NEAR_FULL);
         end
      end
   end

   assign pc_advance = imem_req & imem_gnt;
   assign imem_addr  = pc;

   // redirect overrides both FIFO sides in the cycle it is seen
   assign push       = (state == WAIT) && imem_rvalid && !redirect;
   assign pop        = inst_valid && inst_ready && !redirect;

   assign inst_valid = (count != '0);
   assign inst       = mem_inst[rd_ptr];
   assign inst_pc    = mem_pc[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         req_pc <= '0;
      end else begin
         if (pc_advance) begin
            req_pc <= pc;
         end
         case (state)
            IDLE: begin
               if (pc_advance) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  if (imem_rvalid) begin
                     state <= IDLE;
                  end else begin
                     state <= DROP;
                  end
               end else if (imem_rvalid) begin
                  if (pc_advance) begin
                     state <= WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only read while count says valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_inst[wr_ptr] <= imem_rdata;
         mem_pc[wr_ptr]   <= req_pc;
      end
   end

   a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
      !(push && (count == FULL)));

   a_no_rvalid_in_idle: assert property (@(posedge clock) disable iff (reset)
      !((state == IDLE) && imem_rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. Acts as PC register and instruction memory
//   (grant enable, response latency, data = addr + 0x100) and checks the
//   decode side against hand-derived cycle-by-cycle values plus an in-order
//   queue of granted PCs.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        redirect = 1'b0;
   logic        pc_advance;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   always #5 clock = ~clock;

   fetch_unit #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .pc          (pc),
      .redirect    (redirect),
      .pc_advance  (pc_advance),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // bench-side environment state
   bit          gnt_en = 1'b0;
   int          lat = 1;
   bit          redir_now = 1'b0;
   logic [31:0] redir_target = '0;
   bit          pend_valid = 1'b0;
   int          pend_left = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] expq [$];
   int          first_iv = 0;

   // outputs sampled 1 ns after inputs settle, before the rising edge
   logic        s_req, s_adv, s_iv;
   logic [31:0] s_addr, s_inst, s_ipc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic tick();
      imem_gnt = gnt_en;
      redirect = redir_now;
      if (pend_valid && pend_left == 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend_addr + 32'h100;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      s_req  = imem_req;
      s_adv  = pc_advance;
      s_addr = imem_addr;
      s_iv   = inst_valid;
      s_inst = inst;
      s_ipc  = inst_pc;
      if (s_req) check_val("addr_eq_pc", s_addr, pc);
      check_val("adv_eq_req_and_gnt", {31'b0, s_adv}, {31'b0, s_req & imem_gnt});
      if (s_iv && inst_ready && !redirect) begin
         if (expq.size() == 0) begin
            check_val("sb_unexpected_valid", {31'b0, s_iv}, 32'h0);
         end else begin
            check_val("sb_inst", s_inst, expq[0] + 32'h100);
            check_val("sb_inst_pc", s_ipc, expq[0]);
         end
      end
      @(posedge clock);
      @(negedge clock);
      if (redirect) expq.delete();
      else if (s_iv && inst_ready && expq.size() != 0) void'(expq.pop_front());
      if (pend_valid) begin
         if (pend_left == 1) pend_valid = 1'b0;
         else pend_left--;
      end
      if (s_adv) begin
         expq.push_back(pc);
         pend_valid = 1'b1;
         pend_left  = lat;
         pend_addr  = pc;
      end
      if (redirect) pc = redir_target;
      else if (s_adv) pc = pc + 32'd1;
      redir_now = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      // reset state, with a grant offered to prove the request is gated
      imem_gnt = 1'b1;
      @(negedge clock);
      check_val("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check_val("rst_imem_req",   {31'b0, imem_req},   32'h0);
      check_val("rst_pc_advance", {31'b0, pc_advance}, 32'h0);

      // steady flow, k=1, decode always ready
      reset = 1'b0;
      pc = '0;
      gnt_en = 1'b1;
      inst_ready = 1'b1;
      lat = 1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) check_val("flow_first_req", {31'b0, s_req}, 32'h1);
         if (s_iv && first_iv == 0) first_iv = c;
         if (c >= 3) begin
            check_val("flow_iv", {31'b0, s_iv}, 32'h1);
            check_val("flow_inst", s_inst, 32'h100 + 32'(c - 3));
            check_val("flow_inst_pc", s_ipc, 32'(c - 3));
         end
      end
      check_val("flow_first_valid_cycle", 32'(first_iv), 32'd3);
      check_val("flow_pc_after", pc, 32'd12);

      // backpressure: four entries buffered, fetch stops
      inst_ready = 1'b0;
      for (int c = 13; c <= 20; c++) begin
         tick();
         check_val("bp_head_pc", s_ipc, 32'd10);
         check_val("bp_head_inst", s_inst, 32'h10A);
         if (c >= 15) begin
            check_val("bp_req_low", {31'b0, s_req}, 32'h0);
            check_val("bp_adv_low", {31'b0, s_adv}, 32'h0);
         end
      end
      check_val("bp_pc_held", pc, 32'd14);

      // drain in order, fetch resumes once a slot frees
      inst_ready = 1'b1;
      for (int c = 21; c <= 28; c++) begin
         tick();
         check_val("drain_inst_pc", s_ipc, 32'(c - 11));
         check_val("drain_inst", s_inst, 32'h100 + 32'(c - 11));
         if (c == 21) check_val("drain_req_full", {31'b0, s_req}, 32'h0);
         if (c == 22) begin
            check_val("drain_req_resume", {31'b0, s_req}, 32'h1);
            check_val("drain_addr_resume", s_addr, 32'd14);
         end
      end

      // grant stall for three cycles
      gnt_en = 1'b0;
      for (int c = 29; c <= 31; c++) begin
         tick();
         check_val("stall_req", {31'b0, s_req}, 32'h1);
         check_val("stall_addr", s_addr, 32'd21);
         check_val("stall_adv", {31'b0, s_adv}, 32'h0);
      end
      gnt_en = 1'b1;
      tick();
      check_val("stall_grant_adv", {31'b0, s_adv}, 32'h1);
      check_val("stall_grant_addr", s_addr, 32'd21);
      tick();
      check_val("stall_next_addr", s_addr, 32'd22);

      // redirect one cycle after a k=3 grant, with entries buffered
      inst_ready = 1'b0;
      gnt_en = 1'b0;
      for (int c = 34; c <= 36; c++) tick();
      check_val("pre_redir_iv", {31'b0, s_iv}, 32'h1);
      check_val("pre_redir_head", s_ipc, 32'd21);
      check_val("pre_redir_addr", s_addr, 32'd23);
      lat = 3;
      gnt_en = 1'b1;
      tick();
      check_val("redir_grant_adv", {31'b0, s_adv}, 32'h1);
      redir_now = 1'b1;
      redir_target = 32'h40;
      tick();
      check_val("redir_req_low", {31'b0, s_req}, 32'h0);
      tick();
      check_val("drop_iv_flushed", {31'b0, s_iv}, 32'h0);
      check_val("drop_req_low", {31'b0, s_req}, 32'h0);
      tick();
      check_val("drop_rvalid_req_low", {31'b0, s_req}, 32'h0);
      tick();
      check_val("after_drop_iv", {31'b0, s_iv}, 32'h0);
      check_val("after_drop_req", {31'b0, s_req}, 32'h1);
      check_val("after_drop_addr", s_addr, 32'h40);
      lat = 1;
      tick();
      tick();
      check_val("new_target_wait_iv", {31'b0, s_iv}, 32'h0);
      tick();
      check_val("new_target_rsp_req", {31'b0, s_req}, 32'h1);
      check_val("new_target_rsp_addr", s_addr, 32'h41);

      // redirect coincident with rvalid and inst_ready
      inst_ready = 1'b1;
      redir_now = 1'b1;
      redir_target = 32'h80;
      tick();
      check_val("coinc_head_inst", s_inst, 32'h140);
      check_val("coinc_head_pc", s_ipc, 32'h40);
      check_val("coinc_req_low", {31'b0, s_req}, 32'h0);
      tick();
      check_val("coinc_iv_cleared", {31'b0, s_iv}, 32'h0);
      check_val("coinc_idle_req", {31'b0, s_req}, 32'h1);
      check_val("coinc_idle_addr", s_addr, 32'h80);

      // async reset mid-WAIT with two entries buffered
      inst_ready = 1'b0;
      tick();
      check_val("pre_rst_adv", {31'b0, s_adv}, 32'h1);
      lat = 3;
      tick();
      check_val("pre_rst_adv2", {31'b0, s_adv}, 32'h1);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      redirect = 1'b0;
      #1;
      check_val("pre_rst_iv", {31'b0, inst_valid}, 32'h1);
      check_val("pre_rst_head", inst_pc, 32'h80);
      reset = 1'b1;
      #1;
      check_val("async_rst_iv", {31'b0, inst_valid}, 32'h0);
      check_val("async_rst_req", {31'b0, imem_req}, 32'h0);
      check_val("async_rst_adv", {31'b0, pc_advance}, 32'h0);
      pend_valid = 1'b0;
      expq.delete();
      pc = 32'h300;
      gnt_en = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      check_val("post_rst_req", {31'b0, s_req}, 32'h1);
      check_val("post_rst_addr", s_addr, 32'h300);
      check_val("post_rst_iv", {31'b0, s_iv}, 32'h0);
      tick();
      check_val("post_rst_req_hold", {31'b0, s_req}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
